byte_regfile_wr: RTL

- Write side of the datapath byte register bank: 8 byte registers written through a decoded one-hot write port, read by two combinational byte-select read ports.
- Adds a valid/ready write handshake and a sequenced bank-clear engine that walks every register one per cycle.
- Sits between the control unit and the ALU operand select. Control issues writes and clears; the ALU reads ports A and B.

---
 rtl/byte_regfile_wr_pkg.sv | 20 ++
 rtl/byte_regfile_wr_if.sv | 39 +++
 rtl/byte_regfile_wr_wdec.sv | 25 ++
 rtl/byte_regfile_wr.sv | 135 +++++++++++++
 4 files changed

// File: rtl/byte_regfile_wr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : byte_regfile_wr_pkg                                        |
// | Description : Shared defaults and FSM state encoding for the byte        |
// |               register bank write side.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package byte_regfile_wr_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam logic [7:0] DEF_CLR_VAL = 8'h00;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_regfile_wr_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : byte_regfile_wr_if                                         |
// | Description : Write handshake, clear control and read port bundle of     |
// |               the byte register bank.                                    |
// |   master : control/ALU side (drives write, clear, read addresses)        |
// |   slave  : register bank (drives ready, busy, read data, dirty)          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface byte_regfile_wr_if
    import byte_regfile_wr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREG   = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic              clr_busy;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic [NREG-1:0]   dirty;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req, rd_addr_a, rd_addr_b,
        input  wr_ready, clr_busy, rd_data_a, rd_data_b, dirty
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req, rd_addr_a, rd_addr_b,
        output wr_ready, clr_busy, rd_data_a, rd_data_b, dirty
    );
endinterface
`default_nettype wire

// File: rtl/byte_regfile_wr_wdec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_wdec                                               |
// | Description : Address + enable to one-hot register write strobe.        |
// |   i_addr   : register address                                            |
// |   i_en     : strobe enable                                               |
// |   o_strobe : one-hot write strobe, all zero when disabled                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_wdec #(
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic              i_en,
    output logic      [NREG-1:0]   o_strobe
);
    always_comb begin
        o_strobe = '0;
        if (i_en) begin
            o_strobe[i_addr] = 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/byte_regfile_wr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : byte_regfile_wr                                            |
// | Description : Write side of the datapath byte register bank. NREG       |
// |               registers with a valid/ready write port, a sequenced       |
// |               bank clear (one register per cycle) and two combinational  |
// |               read ports with optional write-to-read bypass.             |
// |   clk  : system clock, rising edge                                       |
// |   rst  : synchronous active-high reset                                   |
// |   bus  : write/clear/read bundle (slave modport)                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module byte_regfile_wr
    import byte_regfile_wr_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                NREG    = 8,
    parameter bit                BYPASS  = 1'b1,
    parameter logic [DATA_W-1:0] CLR_VAL = DEF_CLR_VAL
) (
    input wire logic          clk,
    input wire logic          rst,
    byte_regfile_wr_if.slave  bus
);
    localparam logic [ADDR_W-1:0] c_PTR_LAST = ADDR_W'(NREG - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_dirty;

    logic              w_wr_ready;
    logic              w_clr_busy;
    logic              w_wr_accept;
    logic [NREG-1:0]   w_stb_wr;
    logic [NREG-1:0]   w_stb_clr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_wr_ready  = (r_state == ST_IDLE);
        w_clr_busy  = (r_state == ST_CLEAR);
        case (r_state)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // clr_req is not looked at here, so a repeat request can
                // neither restart nor stretch the sequence.
                if (r_ptr == c_PTR_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear pointer: held at zero outside CLEAR so each sequence starts at
    // register 0; wraps back to zero on its own after the last register.
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_CLEAR)) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= r_ptr + ADDR_W'(1);
        end
    end

    assign w_wr_accept = bus.wr_valid & w_wr_ready;

    regfile_wdec #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_wdec_wr (
        .i_addr   (bus.wr_addr),
        .i_en     (w_wr_accept),
        .o_strobe (w_stb_wr)
    );

    regfile_wdec #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_wdec_clr (
        .i_addr   (r_ptr),
        .i_en     (w_clr_busy),
        .o_strobe (w_stb_clr)
    );

    // Register storage; the clear strobe wins the data select.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                r_regs[i]  <= CLR_VAL;
                r_dirty[i] <= 1'b0;
            end else if (w_stb_clr[i]) begin
                r_regs[i]  <= CLR_VAL;
                r_dirty[i] <= 1'b0;
            end else if (w_stb_wr[i]) begin
                r_regs[i]  <= bus.wr_data;
                r_dirty[i] <= 1'b1;
            end
        end
    end

    // Combinational read ports; bypass forwards only host writes, never
    // clear writes.
    always_comb begin
        bus.rd_data_a = r_regs[bus.rd_addr_a];
        bus.rd_data_b = r_regs[bus.rd_addr_b];
        if (BYPASS && w_wr_accept && (bus.rd_addr_a == bus.wr_addr)) begin
            bus.rd_data_a = bus.wr_data;
        end
        if (BYPASS && w_wr_accept && (bus.rd_addr_b == bus.wr_addr)) begin
            bus.rd_data_b = bus.wr_data;
        end
    end

    assign bus.wr_ready = w_wr_ready;
    assign bus.clr_busy = w_clr_busy;
    assign bus.dirty    = r_dirty;

endmodule
`default_nettype wire
